axi_lite_regbank: RTL and testbench
===================================

Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank, NUM_REGS x DATA_WIDTH. This is the next generation of the fixed four-register 32-bit slave used inside our encoder IP.
- New behaviour over that slave:
  - byte-strobe writes
  - per-register read-only (status) mapping
  - SLVERR on out-of-range or read-only writes
  - independent AW/W acceptance in any order
  - per-register write-commit pulses to the core logic
- Sits between the AXI interconnect/VIP master and the encoder core.

Parameters:
- NUM_REGS, 8, number of registers (1..64).
- DATA_WIDTH, 32, register and bus width; only 32 or 64 allowed.
- ADDR_WIDTH, 6, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes reg i read-only, returning status_in slice i.
- RESET_VAL, 0, NUM_REGS*DATA_WIDTH reset image for the writable registers.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- reg_out  out  NUM_REGS*DATA_WIDTH  flat image of all writable registers; RO slots are driven 0.
- status_in  in  NUM_REGS*DATA_WIDTH  read-only sources; only RO slots are used.
- wr_pulse  out  NUM_REGS  one-cycle pulse on the commit cycle of a successful write to reg i.

Behaviour:
- Clocking and reset: one clock, ACLK. ARESET is asynchronous, active-high.
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0
  - BRESP, RRESP, RDATA = 0
  - wr_pulse = 0
  - registers = RESET_VAL
- Readies: AWREADY, WREADY and ARREADY are registered and rise on the first ACLK edge after ARESET deasserts.
- Register index: idx = addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. idx >= NUM_REGS is out of range.
- Write path: AW and W each have a one-entry holding register.
  - AWREADY = 1 while the AW holder is empty; WREADY = 1 while the W holder is empty.
  - A handshake fills its holder and drops the corresponding ready on the next cycle. AW-first, W-first and same-cycle arrival are all legal.
- Write commit: happens in the cycle when both holders are full and BVALID = 0 (or BVALID && BREADY in that same cycle). On commit:
  - In-range, writable idx: each byte b with WSTRB[b]=1 is updated. BRESP=OKAY. wr_pulse[idx]=1 for exactly that cycle.
  - Out-of-range or RO idx: no state change, no pulse, BRESP=SLVERR.
  - BVALID=1 next cycle; both holders clear and both readies reassert.
- BVALID is held with stable BRESP until BREADY. A write with WSTRB=0 commits with OKAY and a pulse, but changes no data.
- Read path: ARREADY=1 while RVALID=0 and no read is outstanding. On an AR handshake:
  - ARREADY drops.
  - The next cycle has RVALID=1 and RDATA = reg[idx], or status_in slice idx if RO_MASK[idx]. RRESP=OKAY.
  - Out-of-range reads return RDATA=0 with RRESP=SLVERR.
- RDATA/RRESP stay stable until RREADY. ARREADY reasserts the cycle after the R handshake. Minimum read interval is 2 cycles per transaction.
- Read and write paths are fully independent.
- Same-cycle read capture and write commit to the same register: the read returns the pre-write value.
- status_in is sampled on the AR handshake cycle; there is no additional synchronisation.
- Reset mid-transaction: all holders and pending responses are discarded immediately and registers return to RESET_VAL. No B or R response is issued for the aborted transaction.

Test Plan:
- Reset defaults: with RESET_VAL[31:0]=32'hA5A5_0001, read addr 0x00 after reset -> RDATA=32'hA5A5_0001, RRESP=00. Assert ARESET asynchronously mid-cycle -> all VALIDs drop in the same cycle.
- Sequential bank: write 1,2,3..8 to addrs 0x00..0x1C, then read back -> each matches. wr_pulse is one-hot, one cycle, once per write. BRESP=00 throughout.
- Byte strobes: write 32'hFFFF_FFFF, then 32'h1234_5678 with WSTRB=4'b0101 to 0x04 -> readback 32'hFF34_FF78.
- Ordering and stalls: W arrives 3 cycles before AW; next write AW and W in the same cycle; BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY/WREADY stay low, and no second commit until the B handshake.
- RO and range errors: RO_MASK=8'h80, status_in slot 7=32'hDEAD_BEEF.
  - Write to 0x1C -> SLVERR, no pulse.
  - Read 0x1C -> 32'hDEAD_BEEF, OKAY.
  - Read 0x20 -> RDATA 0, SLVERR; write 0x20 -> SLVERR.
- Collision and backpressure: a read of 0x08 is captured in the same cycle as a commit of 32'h55 to 0x08 -> returns the old value; the subsequent read returns 32'h55. RREADY held low 4 cycles -> RDATA stable and ARREADY low.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with byte strobes, read-only status slots,
// SLVERR on bad accesses, independent AW/W capture and per-register commit pulses.
module axi_lite_regbank #(
  parameter int unsigned                    NUM_REGS   = 8,
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = ADDR_WIDTH - OffW;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic                           aw_full_q, aw_full_d;
  logic [IdxW-1:0]                aw_idx_q, aw_idx_d;
  logic                           w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [StrbW-1:0]               wstrb_q, wstrb_d;
  logic                           awready_q, awready_d;
  logic                           wready_q, wready_d;
  logic                           bvalid_q, bvalid_d;
  logic [1:0]                     bresp_q, bresp_d;
  logic                           arready_q, arready_d;
  logic                           rvalid_q, rvalid_d;
  logic [1:0]                     rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

  logic                  aw_hs, w_hs, ar_hs, commit, aw_ok;
  logic [IdxW-1:0]       ar_idx;
  logic [NUM_REGS-1:0]   aw_hit, ar_hit;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OffW-1:0],
                         S_AXI_ARADDR[OffW-1:0]};

  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:OffW];

  // Write path: two one-entry holders, commit when both full and B slot free.
  always_comb begin
    aw_hs  = S_AXI_AWVALID & awready_q;
    w_hs   = S_AXI_WVALID & wready_q;
    commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);

    aw_hit = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      aw_hit[i] = (aw_idx_q == IdxW'(i));
    end
    aw_ok    = |(aw_hit & ~RO_MASK);
    wr_pulse = commit ? (aw_hit & ~RO_MASK) : '0;

    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:OffW];
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end
    end
    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;

    bvalid_d = commit | (bvalid_q & ~S_AXI_BREADY);
    bresp_d  = commit ? (aw_ok ? RespOkay : RespSlvErr) : bresp_q;

    regs_d = regs_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wr_pulse[i] && wstrb_q[b]) begin
          regs_d[i*DATA_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // Read path: source is the pre-commit register image, so a same-cycle
  // commit to the addressed register is not visible to this read.
  always_comb begin
    ar_hs  = S_AXI_ARVALID & arready_q;
    ar_hit = '0;
    rd_sel = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      ar_hit[i] = (ar_idx == IdxW'(i));
      if (ar_hit[i]) begin
        rd_sel = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH]
                            : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
    arready_d = ~ar_hs & ~rvalid_d;
    rdata_d   = ar_hs ? rd_sel : rdata_q;
    rresp_d   = ar_hs ? ((|ar_hit) ? RespOkay : RespSlvErr) : rresp_q;
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (!RO_MASK[i]) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      regs_q    <= RESET_VAL;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed self-checking bench for axi_lite_regbank (8 x 32, slot 7 read-only).
module tb_axi_lite_regbank;

  logic        clk = 1'b0;
  logic        ARESET;
  logic [5:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [255:0] reg_out;
  logic [255:0] status_in;
  logic [7:0]  wr_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int multi_hot = 0;
  logic [7:0] last_pulse = '0;

  axi_lite_regbank #(
    .NUM_REGS  (8),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(6),
    .RO_MASK   (8'h80),
    .RESET_VAL ({224'h0, 32'hA5A5_0001})
  ) dut (
    .ACLK         (clk),
    .ARESET       (ARESET),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .reg_out      (reg_out),
    .status_in    (status_in),
    .wr_pulse     (wr_pulse)
  );

  always #5 clk = ~clk;

  // wr_pulse is combinational in the commit cycle; observe it mid-cycle.
  always @(negedge clk) begin
    if (wr_pulse != 8'h00) begin
      pulse_cnt++;
      last_pulse = wr_pulse;
      if ($countones(wr_pulse) != 1) multi_hot++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    int c = 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && c < 50) begin
      S_AXI_AWVALID = !aw_done && (c >= aw_dly);
      S_AXI_WVALID  = !w_done && (c >= w_dly);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      c++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
    c = 0;
    while (!S_AXI_BVALID && c < 50) begin
      tick();
      c++;
    end
    check("bvalid_seen", S_AXI_BVALID, 1'b1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] exp_resp, input logic [7:0] exp_pulse);
    logic [1:0] resp;
    int p0 = pulse_cnt;
    axi_write(addr, data, strb, aw_dly, w_dly, resp);
    check({tag, "_bresp"}, resp, exp_resp);
    check({tag, "_npulse"}, pulse_cnt - p0, (exp_pulse != 8'h00) ? 1 : 0);
    if (exp_pulse != 8'h00) check({tag, "_pulse"}, last_pulse, exp_pulse);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit hs = 0;
    int c = 0;
    logic [31:0] d0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!hs && c < 50) begin
      hs = S_AXI_ARREADY;
      tick();
      c++;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_accept", hs, 1'b1);
    c = 0;
    while (!S_AXI_RVALID && c < 50) begin
      tick();
      c++;
    end
    check("rvalid_seen", S_AXI_RVALID, 1'b1);
    d0 = S_AXI_RDATA;
    for (int k = 0; k < r_dly; k++) begin
      tick();
      check("r_stall_data", S_AXI_RDATA, d0);
      check("r_stall_arready", S_AXI_ARREADY, 1'b0);
      check("r_stall_rvalid", S_AXI_RVALID, 1'b1);
    end
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [5:0] addr, input int r_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(addr, r_dly, d, r);
    check({tag, "_rdata"}, d, exp_data);
    check({tag, "_rresp"}, r, exp_resp);
  endtask

  initial begin
    int p0;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    status_in = {32'hDEAD_BEEF, {7{32'hBAD0_0BAD}}};

    repeat (3) tick();
    ARESET = 1'b0;
    check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
    check("rst_pulse", wr_pulse, 8'h00);
    tick();
    check("ready_rise", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    do_read("rst_reg0", 6'h00, 0, 32'hA5A5_0001, 2'b00);

    // Writable slots 0..6 get 1..7; slot 7 is status.
    for (int i = 0; i < 7; i++) do_write("seq_wr", 6'(4*i), 32'(i+1), 4'hF, 0, 0, 2'b00, 8'(1 << i));
    for (int i = 0; i < 7; i++) do_read("seq_rd", 6'(4*i), 0, 32'(i+1), 2'b00);
    check("reg_out_img", reg_out, {32'h0, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1});

    do_write("strb_full", 6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, 8'h02);
    do_write("strb_0101", 6'h04, 32'h1234_5678, 4'b0101, 0, 0, 2'b00, 8'h02);
    do_read("strb_rd", 6'h04, 0, 32'hFF34_FF78, 2'b00);
    do_write("strb_none", 6'h05, 32'h0000_0000, 4'h0, 0, 0, 2'b00, 8'h02);
    do_read("strb_none_rd", 6'h04, 0, 32'hFF34_FF78, 2'b00);

    do_write("w_early", 6'h0C, 32'hCAFE_0003, 4'hF, 3, 0, 2'b00, 8'h08);
    do_read("w_early_rd", 6'h0C, 0, 32'hCAFE_0003, 2'b00);
    do_write("aw_early", 6'h0C, 32'hBEEF_0004, 4'hF, 0, 2, 2'b00, 8'h08);
    do_read("aw_early_rd", 6'h0C, 0, 32'hBEEF_0004, 2'b00);

    // B backpressure with a second write queued behind it.
    S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    check("stall_bvalid0", S_AXI_BVALID, 1'b1);
    S_AXI_AWADDR = 6'h14; S_AXI_WDATA = 32'h22;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      check("stall_bvalid", S_AXI_BVALID, 1'b1);
      check("stall_bresp", S_AXI_BRESP, 2'b00);
      check("stall_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      tick();
    end
    check("stall_no_commit", pulse_cnt, p0);
    S_AXI_BREADY = 1'b1;
    tick();
    check("stall_commit", pulse_cnt, p0 + 1);
    check("stall_pulse", last_pulse, 8'h20);
    check("stall_b2", S_AXI_BVALID, 1'b1);
    tick();
    S_AXI_BREADY = 1'b0;
    check("stall_b_done", S_AXI_BVALID, 1'b0);
    do_read("stall_rd_a", 6'h10, 0, 32'h11, 2'b00);
    do_read("stall_rd_b", 6'h14, 0, 32'h22, 2'b00);

    do_write("ro_wr", 6'h1C, 32'h1234_0000, 4'hF, 0, 0, 2'b10, 8'h00);
    do_read("ro_rd", 6'h1C, 0, 32'hDEAD_BEEF, 2'b00);
    check("ro_reg_out", reg_out[255:224], 32'h0);
    do_read("oor_rd", 6'h20, 0, 32'h0, 2'b10);
    do_write("oor_wr", 6'h20, 32'h9999_9999, 4'hF, 0, 0, 2'b10, 8'h00);
    do_read("oor_rd_hi", 6'h3C, 0, 32'h0, 2'b10);

    // Read capture coincides with commit to the same register.
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
    p0 = pulse_cnt;
    tick();
    S_AXI_ARVALID = 1'b0;
    check("coll_rvalid", S_AXI_RVALID, 1'b1);
    check("coll_old", S_AXI_RDATA, 32'h3);
    check("coll_bvalid", S_AXI_BVALID, 1'b1);
    check("coll_pulse", {pulse_cnt - p0, 24'h0, last_pulse}, {32'd1, 24'h0, 8'h04});
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    do_read("coll_new", 6'h08, 4, 32'h55, 2'b00);

    // Asynchronous reset with both responses pending.
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tick();
    check("pre_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("pre_rst_reg0", reg_out[31:0], 32'h77);
    #3;
    ARESET = 1'b1;
    #1;
    check("mid_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("mid_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("mid_rst_regs", reg_out, {224'h0, 32'hA5A5_0001});
    tick();
    ARESET = 1'b0;
    tick();
    check("post_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    do_read("post_rst_reg0", 6'h00, 0, 32'hA5A5_0001, 2'b00);
    do_read("post_rst_reg1", 6'h04, 0, 32'h0, 2'b00);
    check("pulse_onehot", multi_hot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
